// File: rtl/mem_responder.sv
// Word-wide on-chip RAM responder for the mem_in_type/mem_out_type bus.
// Every accepted request gets exactly one mem_ready pulse after mem_latency cycles.
package mem_responder_pkg;

    typedef struct packed {
        logic        mem_valid;
        logic        mem_fence;
        logic        mem_instr;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [3:0]  mem_wstrb;
    } mem_in_type;

    typedef struct packed {
        logic [31:0] mem_rdata;
        logic        mem_ready;
    } mem_out_type;

endpackage

module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int unsigned mem_depth   = 1024,
    parameter logic [31:0] mem_base    = 32'h0,
    parameter int unsigned mem_latency = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  mem_in_type  mem_in,
    output mem_out_type mem_out,
    output logic        mem_err,
    output logic        busy
);

    localparam int unsigned addr_w   = $clog2(mem_depth);
    localparam int unsigned cnt_w    = 4;
    localparam logic [32:0] range_lo = 33'(mem_base);
    localparam logic [32:0] span     = 33'(mem_depth) << 2;
    localparam logic [cnt_w-1:0] cnt_load = cnt_w'(mem_latency - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t            state, state_next;
    logic [cnt_w-1:0]  cnt, cnt_next;
    logic [31:0]       ram [mem_depth];

    logic [31:0]       rdata_hold;
    logic              err_hold;
    logic              ready_q;
    logic [31:0]       rdata_q;
    logic              err_q;
    logic              busy_q;

    logic [32:0]       offset_c;
    logic [addr_w-1:0] idx_c;
    logic              in_range_c;
    logic              accept_c;
    logic              wr_en_c;
    logic [31:0]       resp_data_c;
    logic              resp_err_c;
    logic              unused_instr;

    assign unused_instr = mem_in.mem_instr;

    // Request decode; 33-bit offset so a range ending at 2^32 does not wrap.
    always_comb begin
        offset_c    = {1'b0, mem_in.mem_addr} - range_lo;
        idx_c       = addr_w'(offset_c[31:2]);
        in_range_c  = !offset_c[32] && (offset_c < span);
        accept_c    = mem_in.mem_valid && (state == IDLE || state == RESP);
        wr_en_c     = accept_c && !mem_in.mem_fence && in_range_c && (mem_in.mem_wstrb != 4'h0);
        resp_data_c = 32'h0;
        resp_err_c  = 1'b0;
        if (mem_in.mem_fence) begin
            resp_data_c = 32'h0;
        end else if (!in_range_c) begin
            resp_err_c = 1'b1;
        end else if (mem_in.mem_wstrb == 4'h0) begin
            resp_data_c = ram[idx_c];
        end
    end

    // Next-state logic; an accept in RESP restarts the latency without a gap.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                state_next = IDLE;
            end
            WAIT: begin
                if (cnt == cnt_w'(1)) begin
                    state_next = RESP;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt - cnt_w'(1);
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
        if (accept_c) begin
            if (mem_latency == 1) begin
                state_next = RESP;
                cnt_next   = '0;
            end else begin
                state_next = WAIT;
                cnt_next   = cnt_load;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            ready_q    <= 1'b0;
            rdata_q    <= 32'h0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            rdata_hold <= 32'h0;
            err_hold   <= 1'b0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            ready_q <= (state_next == RESP);
            busy_q  <= (state_next != IDLE);
            if (accept_c) begin
                rdata_hold <= resp_data_c;
                err_hold   <= resp_err_c;
            end
            if (state_next == RESP) begin
                rdata_q <= accept_c ? resp_data_c : rdata_hold;
                err_q   <= accept_c ? resp_err_c : err_hold;
            end else begin
                rdata_q <= 32'h0;
                err_q   <= 1'b0;
            end
        end
    end

    // Byte-lane write commits at the accept edge, so a following read sees it.
    always_ff @(posedge clock) begin
        if (reset && wr_en_c) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_in.mem_wstrb[b]) begin
                    ram[idx_c][8*b +: 8] <= mem_in.mem_wdata[8*b +: 8];
                end
            end
        end
    end

    assign mem_out.mem_rdata = rdata_q;
    assign mem_out.mem_ready = ready_q;
    assign mem_err           = err_q;
    assign busy              = busy_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench: three responders at latencies 1, 2 and 3 sharing clock and reset.
module tb_mem_responder;
    import mem_responder_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    mem_in_type  req  [3];
    mem_out_type rsp  [3];
    logic        err  [3];
    logic        busy [3];
    int          checks = 0;
    int          errors = 0;

    always #5 clock = ~clock;

    mem_responder #(.mem_depth(1024), .mem_base(32'h0), .mem_latency(1)) u_lat1 (
        .clock(clock), .reset(reset), .mem_in(req[0]), .mem_out(rsp[0]), .mem_err(err[0]), .busy(busy[0]));
    mem_responder #(.mem_depth(1024), .mem_base(32'h0), .mem_latency(2)) u_lat2 (
        .clock(clock), .reset(reset), .mem_in(req[1]), .mem_out(rsp[1]), .mem_err(err[1]), .busy(busy[1]));
    mem_responder #(.mem_depth(1024), .mem_base(32'h0), .mem_latency(3)) u_lat3 (
        .clock(clock), .reset(reset), .mem_in(req[2]), .mem_out(rsp[2]), .mem_err(err[2]), .busy(busy[2]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input int i, input string tag);
        check({tag, " ready"}, 32'(rsp[i].mem_ready), 32'h0);
        check({tag, " rdata"}, rsp[i].mem_rdata, 32'h0);
        check({tag, " err"}, 32'(err[i]), 32'h0);
        check({tag, " busy"}, 32'(busy[i]), 32'h0);
    endtask

    task automatic drive(input int i, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic f);
        req[i] = '{mem_valid: 1'b1, mem_fence: f, mem_instr: 1'b0,
                   mem_addr: a, mem_wdata: d, mem_wstrb: s};
    endtask

    // Called at the first falling edge after the accept edge; ends on the ready cycle.
    task automatic expect_resp(input int i, input int lat, input logic [31:0] rd,
                               input logic er, input string tag);
        for (int k = 1; k < lat; k++) begin
            check({tag, " early ready"}, 32'(rsp[i].mem_ready), 32'h0);
            check({tag, " wait busy"}, 32'(busy[i]), 32'h1);
            @(negedge clock);
        end
        check({tag, " ready"}, 32'(rsp[i].mem_ready), 32'h1);
        check({tag, " rdata"}, rsp[i].mem_rdata, rd);
        check({tag, " err"}, 32'(err[i]), 32'(er));
        check({tag, " resp busy"}, 32'(busy[i]), 32'h1);
    endtask

    task automatic txn(input int i, input int lat, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic f, input logic [31:0] rd,
                       input logic er, input string tag);
        drive(i, a, d, s, f);
        @(negedge clock);
        req[i] = '0;
        expect_resp(i, lat, rd, er, tag);
        @(negedge clock);
        check_idle(i, {tag, " after"});
    endtask

    initial begin
        reset = 1'b0;
        for (int i = 0; i < 3; i++) req[i] = '0;
        repeat (3) @(negedge clock);
        for (int i = 0; i < 3; i++) check_idle(i, $sformatf("reset u%0d", i));
        reset = 1'b1;
        repeat (5) @(negedge clock);
        for (int i = 0; i < 3; i++) check_idle(i, $sformatf("idle u%0d", i));

        // Reset during an outstanding request: no ready may ever appear.
        drive(2, 32'h20, 32'h0, 4'h0, 1'b0);
        @(negedge clock);
        req[2] = '0;
        check("midreset accepted busy", 32'(busy[2]), 32'h1);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        for (int k = 0; k < 6; k++) begin
            check("midreset no ready", 32'(rsp[2].mem_ready), 32'h0);
            @(negedge clock);
        end
        check_idle(2, "midreset end");

        // Latency 1: write then back-to-back read in the ready cycle.
        drive(0, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0);
        @(negedge clock);
        expect_resp(0, 1, 32'h0, 1'b0, "l1 write");
        drive(0, 32'h10, 32'h0, 4'h0, 1'b0);
        @(negedge clock);
        expect_resp(0, 1, 32'hDEADBEEF, 1'b0, "l1 b2b read");
        req[0] = '0;
        @(negedge clock);
        check_idle(0, "l1 b2b after");

        // Out-of-range accesses must not alias onto words 0x0 or 0xFFC.
        txn(0, 1, 32'h0, 32'h01020304, 4'hF, 1'b0, 32'h0, 1'b0, "seed 0x0");
        txn(0, 1, 32'hFFC, 32'h0BADF00D, 4'hF, 1'b0, 32'h0, 1'b0, "seed 0xffc");
        txn(0, 1, 32'h1000, 32'h0, 4'h0, 1'b0, 32'h0, 1'b1, "oor read");
        txn(0, 1, 32'hFFFFFFFC, 32'hFFFFFFFF, 4'hF, 1'b0, 32'h0, 1'b1, "oor write");
        txn(0, 1, 32'h0, 32'h0, 4'h0, 1'b0, 32'h01020304, 1'b0, "reread 0x0");
        txn(0, 1, 32'hFFC, 32'h0, 4'h0, 1'b0, 32'h0BADF00D, 1'b0, "reread 0xffc");

        // Fence carries write-looking fields but must leave RAM untouched.
        txn(0, 1, 32'h10, 32'h12345678, 4'hF, 1'b1, 32'h0, 1'b0, "fence");
        txn(0, 1, 32'h10, 32'h0, 4'h0, 1'b0, 32'hDEADBEEF, 1'b0, "post fence read");

        // Latency 3: partial write, then a read accepted in its ready cycle.
        txn(2, 3, 32'h20, 32'hAABBCCDD, 4'hF, 1'b0, 32'h0, 1'b0, "l3 seed");
        drive(2, 32'h20, 32'h11223344, 4'b0101, 1'b0);
        @(negedge clock);
        req[2] = '0;
        expect_resp(2, 3, 32'h0, 1'b0, "l3 strb write");
        drive(2, 32'h20, 32'h0, 4'h0, 1'b0);
        @(negedge clock);
        req[2] = '0;
        expect_resp(2, 3, 32'hAA22CC44, 1'b0, "l3 b2b read");
        @(negedge clock);
        check_idle(2, "l3 after");

        // Latency 2: valid held through WAIT with a new address is ignored.
        txn(1, 2, 32'h4, 32'h44444444, 4'hF, 1'b0, 32'h0, 1'b0, "l2 seed 0x4");
        txn(1, 2, 32'h8, 32'h88888888, 4'hF, 1'b0, 32'h0, 1'b0, "l2 seed 0x8");
        drive(1, 32'h4, 32'h0, 4'h0, 1'b0);
        @(negedge clock);
        req[1].mem_addr = 32'h8;
        check("l2 hold early ready", 32'(rsp[1].mem_ready), 32'h0);
        check("l2 hold wait busy", 32'(busy[1]), 32'h1);
        @(negedge clock);
        req[1] = '0;
        check("l2 hold ready", 32'(rsp[1].mem_ready), 32'h1);
        check("l2 hold rdata", rsp[1].mem_rdata, 32'h44444444);
        @(negedge clock);
        check_idle(1, "l2 hold after");
        @(negedge clock);
        check_idle(1, "l2 hold no second");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
